// File: rtl/gray_mon_pkg.sv
// +----------------------------------------------------------------------+
// | gray_mon_pkg : shared types and helpers for gray_stream_monitor      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package gray_mon_pkg;

  typedef enum logic [0:0] {
    SEED  = 1'b0,
    TRACK = 1'b1
  } mon_state_e;

  localparam int unsigned FN_W = 32;

  // Helpers work on a fixed 32-bit container; callers zero-extend narrower codes.
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [FN_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < FN_W; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_mon_sync.sv
// +----------------------------------------------------------------------+
// | gray_mon_sync : 2-flop synchronizer (used under GRAY_MON_SYNC_EN)    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module gray_mon_sync #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/gray_stream_monitor.sv
// +----------------------------------------------------------------------+
// | gray_stream_monitor : gray-to-binary recovery and step checker       |
// | Optional input synchronizer: define GRAY_MON_SYNC_EN                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

import gray_mon_pkg::*;

module gray_stream_monitor #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 gray_valid,
  input  logic                 clear_err,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 dir_up,
  output logic                 hold,
  output logic                 step_err,
  output logic                 wrap,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic [WIDTH-1:0] src_gray;
  logic             src_valid;
  logic             src_clr;

`ifdef GRAY_MON_SYNC_EN
  logic [WIDTH:0] sync_out;
  logic [1:0]     clr_dly_q;

  gray_mon_sync #(.W(WIDTH + 1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({gray_valid, gray_in}),
    .q_o (sync_out)
  );

  // clear_err is local; delay it to stay aligned with the synchronized sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_dly_q <= '0;
    end else begin
      clr_dly_q <= {clr_dly_q[0], clear_err};
    end
  end

  assign src_gray  = sync_out[WIDTH-1:0];
  assign src_valid = sync_out[WIDTH];
  assign src_clr   = clr_dly_q[1];
`else
  assign src_gray  = gray_in;
  assign src_valid = gray_valid;
  assign src_clr   = clear_err;
`endif

  logic [WIDTH-1:0]     s1_gray_q;
  logic                 s1_valid_q;
  logic                 s1_clr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_gray_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_clr_q   <= 1'b0;
    end else begin
      s1_gray_q  <= src_gray;
      s1_valid_q <= src_valid;
      s1_clr_q   <= src_clr;
    end
  end

  mon_state_e           state_q;
  logic [WIDTH-1:0]     prev_gray_q;
  logic [WIDTH-1:0]     prev_bin_q;
  logic [WIDTH-1:0]     bin_out_q;
  logic                 bin_valid_q;
  logic                 dir_up_q;
  logic                 hold_q;
  logic                 step_err_q;
  logic                 wrap_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic [FN_W-1:0]  s1_bin32;
  logic [WIDTH-1:0] s1_bin;
  logic [5:0]       hd;
  logic [WIDTH-1:0] prev_inc;

  assign s1_bin32 = gray2bin(FN_W'(s1_gray_q));
  assign s1_bin   = s1_bin32[WIDTH-1:0];
  assign hd       = popcount(FN_W'(s1_gray_q ^ prev_gray_q));
  assign prev_inc = prev_bin_q + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEED;
      prev_gray_q <= '0;
      prev_bin_q  <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      dir_up_q    <= 1'b1;
      hold_q      <= 1'b0;
      step_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      bin_valid_q <= 1'b0;
      hold_q      <= 1'b0;
      step_err_q  <= 1'b0;
      wrap_q      <= 1'b0;

      if (s1_valid_q) begin
        bin_valid_q <= 1'b1;
        bin_out_q   <= s1_bin;
        prev_gray_q <= s1_gray_q;
        prev_bin_q  <= s1_bin;
        state_q     <= TRACK;
      end

      // A clear re-seeds: any sample arriving with it raises no flags.
      if (s1_clr_q) begin
        err_count_q <= '0;
        if (!s1_valid_q) begin
          state_q <= SEED;
        end
      end else if (s1_valid_q && state_q == TRACK) begin
        if (hd == 6'd0) begin
          hold_q <= 1'b1;
        end else if (hd == 6'd1) begin
          dir_up_q <= (s1_bin32 == FN_W'(prev_inc));
          wrap_q   <= (prev_bin_q == '1) && (s1_bin32 == '0);
        end else begin
          step_err_q <= 1'b1;
          if (err_count_q != '1) begin
            err_count_q <= err_count_q + ERR_CNT_W'(1);
          end
        end
      end
    end
  end

  assign bin_out   = bin_out_q;
  assign bin_valid = bin_valid_q;
  assign dir_up    = dir_up_q;
  assign hold      = hold_q;
  assign step_err  = step_err_q;
  assign wrap      = wrap_q;
  assign err_count = err_count_q;

endmodule

`default_nettype wire
